// File: rtl/range_buffer_ctrl.sv
// range_buffer_ctrl: arbitrates two allocation requesters and a check port onto
// the allocation range buffer, sequences its clear, and tracks occupancy/overwrite.
module range_buffer_ctrl #(
    parameter int unsigned SIZE = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_a_valid_i,
    output logic                      alloc_a_ready_o,
    input  logic [31:0]               alloc_a_first_i,
    input  logic [31:0]               alloc_a_last_i,
    input  logic                      alloc_b_valid_i,
    output logic                      alloc_b_ready_o,
    input  logic [31:0]               alloc_b_first_i,
    input  logic [31:0]               alloc_b_last_i,
    input  logic                      chk_valid_i,
    output logic                      chk_ready_o,
    input  logic [31:0]               chk_addr_i,
    output logic                      chk_valid_o,
    output logic                      chk_hit_o,
    input  logic                      clear_req_i,
    output logic                      clear_done_o,
    output logic                      buf_en_write_o,
    output logic [31:0]               buf_addr_first_o,
    output logic [31:0]               buf_addr_last_o,
    output logic                      buf_rst_us_o,
    output logic [31:0]               buf_find_addr_o,
    input  logic                      buf_in_range_i,
    output logic [$clog2(SIZE):0]     count_o,
    output logic                      wrapped_o,
    output logic                      err_o
);

    localparam int unsigned CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] FULL = CW'(SIZE);

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, CLEAR} state_t;

    state_t          state_q, state_d;
    logic            rr_q, chk_last_q;
    logic [31:0]     first_q, last_q, addr_q;
    logic            hit_q, chk_valid_q, clear_done_q;
    logic [CW-1:0]   count_q;
    logic            wrapped_q;

    logic is_idle, clr_take, any_alloc, alloc_go;
    logic a_fire, b_fire, c_fire, wr_ok;

    // Handshake arbitration: clear, then check (unless alloc is owed a turn), then round-robin alloc.
    // A clear request still high during the done pulse is the one just served, so it is ignored.
    always_comb begin
        is_idle         = (state_q == IDLE) && !rst_i;
        clr_take        = clear_req_i && !clear_done_q;
        any_alloc       = alloc_a_valid_i || alloc_b_valid_i;
        chk_ready_o     = is_idle && !clr_take && !(chk_last_q && any_alloc);
        alloc_go        = is_idle && !clr_take && (!chk_valid_i || chk_last_q);
        alloc_a_ready_o = alloc_go && (!rr_q || !alloc_b_valid_i);
        alloc_b_ready_o = alloc_go && (rr_q || !alloc_a_valid_i);
        a_fire          = alloc_a_valid_i && alloc_a_ready_o;
        b_fire          = alloc_b_valid_i && alloc_b_ready_o;
        c_fire          = chk_valid_i && chk_ready_o;
        wr_ok           = (first_q <= last_q);
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_d        = state_q;
        buf_en_write_o = 1'b0;
        err_o          = 1'b0;
        buf_rst_us_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_idle && clr_take)     state_d = CLEAR;
                else if (c_fire)             state_d = CHECK;
                else if (a_fire || b_fire)   state_d = WRITE;
            end
            WRITE: begin
                buf_en_write_o = wr_ok;
                err_o          = !wr_ok;
                state_d        = IDLE;
            end
            CHECK: state_d = IDLE;
            CLEAR: begin
                buf_rst_us_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Captured request data, arbitration flags, result/done pulses and occupancy tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= 1'b0;
            chk_last_q   <= 1'b0;
            first_q      <= '0;
            last_q       <= '0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            chk_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
        end else begin
            chk_valid_q  <= (state_q == CHECK);
            clear_done_q <= (state_q == CLEAR);
            if (state_q == CHECK) hit_q <= buf_in_range_i;
            if (c_fire) begin
                addr_q     <= chk_addr_i;
                chk_last_q <= 1'b1;
            end else if (a_fire || b_fire) begin
                first_q    <= a_fire ? alloc_a_first_i : alloc_b_first_i;
                last_q     <= a_fire ? alloc_a_last_i  : alloc_b_last_i;
                rr_q       <= !rr_q;
                chk_last_q <= 1'b0;
            end
            if (state_q == WRITE && wr_ok) begin
                if (count_q == FULL) wrapped_q <= 1'b1;
                else                 count_q   <= count_q + 1'b1;
            end
            if (state_q == CLEAR) begin
                count_q   <= '0;
                wrapped_q <= 1'b0;
            end
        end
    end

    assign buf_addr_first_o = first_q;
    assign buf_addr_last_o  = last_q;
    assign buf_find_addr_o  = addr_q;
    assign chk_valid_o      = chk_valid_q;
    assign chk_hit_o        = chk_valid_q && hit_q;
    assign clear_done_o     = clear_done_q;
    assign count_o          = count_q;
    assign wrapped_o        = wrapped_q;

endmodule

// File: tb/tb_range_buffer_ctrl.sv
// tb_range_buffer_ctrl: drives directed and random traffic, models the range
// buffer itself, and compares every cycle against a transaction-level reference.
module tb_range_buffer_ctrl;

    localparam int unsigned SIZE = 32;
    localparam int unsigned CW   = $clog2(SIZE) + 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic a_v = 1'b0, b_v = 1'b0, c_v = 1'b0, clr = 1'b0;
    logic [31:0] a_f = '0, a_l = '0, b_f = '0, b_l = '0, c_a = '0;
    logic a_r, b_r, c_r, cvo, hito, done, en, brst, inr, wrp, err;
    logic [31:0] wf, wl, find;
    logic [CW-1:0] cnt;

    always #5 clk_i = ~clk_i;

    range_buffer_ctrl #(.SIZE(SIZE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_a_valid_i(a_v), .alloc_a_ready_o(a_r), .alloc_a_first_i(a_f), .alloc_a_last_i(a_l),
        .alloc_b_valid_i(b_v), .alloc_b_ready_o(b_r), .alloc_b_first_i(b_f), .alloc_b_last_i(b_l),
        .chk_valid_i(c_v), .chk_ready_o(c_r), .chk_addr_i(c_a),
        .chk_valid_o(cvo), .chk_hit_o(hito),
        .clear_req_i(clr), .clear_done_o(done),
        .buf_en_write_o(en), .buf_addr_first_o(wf), .buf_addr_last_o(wl),
        .buf_rst_us_o(brst), .buf_find_addr_o(find), .buf_in_range_i(inr),
        .count_o(cnt), .wrapped_o(wrp), .err_o(err)
    );

    // Behavioural range buffer: circular store written by the DUT strobe, combinational lookup.
    logic [31:0] bf_m [SIZE];
    logic [31:0] bl_m [SIZE];
    logic        bv_m [SIZE];
    int unsigned wp;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || brst) begin
            for (int i = 0; i < int'(SIZE); i++) bv_m[i] <= 1'b0;
            wp <= 0;
        end else if (en) begin
            bf_m[wp] <= wf;
            bl_m[wp] <= wl;
            bv_m[wp] <= 1'b1;
            wp       <= (wp + 1) % SIZE;
        end
    end

    always_comb begin
        inr = 1'b0;
        for (int i = 0; i < int'(SIZE); i++)
            if (bv_m[i] && bf_m[i] <= find && find <= bl_m[i]) inr = 1'b1;
    end

    // Reference model: pending operation, arbitration history, list of live ranges.
    typedef struct { logic [31:0] f; logic [31:0] l; } rng_t;
    typedef enum int {P_IDLE, P_WR, P_CHK, P_CLR} phase_t;
    rng_t        rq[$];
    phase_t      ph;
    logic        m_rr, m_chk_last, m_cv, m_hit, m_done, m_wrapped;
    int unsigned m_count;
    logic [31:0] pf, pl, paddr;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        foreach (rq[i]) if (rq[i].f <= a && a <= rq[i].l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        rq.delete();
        ph = P_IDLE; m_rr = 0; m_chk_last = 0; m_cv = 0; m_hit = 0; m_done = 0;
        m_wrapped = 0; m_count = 0; pf = '0; pl = '0; paddr = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_strobes", {a_r, b_r, c_r, cvo, hito, done, en, brst, err, wrp}, '0);
        check_eq("rst_count", 64'(cnt), '0);
        check_eq("rst_wdata", {wf, wl}, '0);
        check_eq("rst_find", 64'(find), '0);
    endtask

    // One clock of traffic: drive, compare against the model, then advance the model.
    task automatic step(input logic av, input logic [31:0] af, input logic [31:0] al,
                        input logic bv, input logic [31:0] bf, input logic [31:0] bl,
                        input logic cv, input logic [31:0] ca, input logic cr);
        logic g_a, g_b, g_c, clr_eff, e_en, e_err;
        logic n_cv, n_hit, n_done;
        @(negedge clk_i);
        a_v = av; a_f = af; a_l = al; b_v = bv; b_f = bf; b_l = bl;
        c_v = cv; c_a = ca; clr = cr;
        #1;
        g_a = 0; g_b = 0; g_c = 0;
        clr_eff = cr && !m_done;
        if (ph == P_IDLE && !clr_eff) begin
            if (cv && !(m_chk_last && (av || bv))) g_c = 1;
            else if (av && (!bv || !m_rr))        g_a = 1;
            else if (bv)                          g_b = 1;
        end
        e_en  = (ph == P_WR) && (pf <= pl);
        e_err = (ph == P_WR) && (pf > pl);
        check_eq("grant", {a_v & a_r, b_v & b_r, c_v & c_r}, {g_a, g_b, g_c});
        if (ph != P_IDLE) check_eq("busy_ready", {a_r, b_r, c_r}, '0);
        check_eq("strobes", {en, err, cvo, hito, brst, done},
                 {e_en, e_err, m_cv, m_cv & m_hit, ph == P_CLR, m_done});
        check_eq("occupancy", {wrp, cnt}, {m_wrapped, CW'(m_count)});
        if (e_en) check_eq("wdata", {wf, wl}, {pf, pl});
        if (ph == P_CHK) check_eq("find_addr", 64'(find), 64'(paddr));
        @(posedge clk_i);
        n_cv = 0; n_hit = 0; n_done = 0;
        case (ph)
            P_IDLE: begin
                if (clr_eff) ph = P_CLR;
                else if (g_c) begin paddr = ca; m_chk_last = 1; ph = P_CHK; end
                else if (g_a || g_b) begin
                    pf = g_a ? af : bf; pl = g_a ? al : bl;
                    m_rr = !m_rr; m_chk_last = 0; ph = P_WR;
                end
            end
            P_WR: begin
                if (pf <= pl) begin
                    if (rq.size() == SIZE) void'(rq.pop_front());
                    rq.push_back('{f: pf, l: pl});
                    if (m_count == SIZE) m_wrapped = 1; else m_count++;
                end
                ph = P_IDLE;
            end
            P_CHK: begin n_cv = 1; n_hit = model_hit(paddr); ph = P_IDLE; end
            P_CLR: begin rq.delete(); m_count = 0; m_wrapped = 0; n_done = 1; ph = P_IDLE; end
            default: ph = P_IDLE;
        endcase
        m_cv = n_cv; m_hit = n_hit; m_done = n_done;
    endtask

    task automatic idle_step();
        step(0, '0, '0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic clear_cycle();
        int n = 0;
        while (!m_done && n < 10) begin step(0, '0, '0, 0, '0, '0, 0, '0, 1); n++; end
        if (n >= 10) check_eq("clear_timeout", 1, 0);
        step(0, '0, '0, 0, '0, '0, 0, '0, 1);
        idle_step();
    endtask

    initial begin
        logic [31:0] f, l;
        logic cr_lvl;
        int n;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 check_reset_outputs();
        @(negedge clk_i) rst_i = 1'b0;

        step(1, 32'h1000, 32'h10FF, 0, '0, '0, 0, '0, 0);
        idle_step();
        step(0, '0, '0, 0, '0, '0, 1, 32'h10FF, 0);
        idle_step(); idle_step();
        step(0, '0, '0, 0, '0, '0, 1, 32'h1100, 0);
        idle_step(); idle_step();

        for (int i = 0; i < 8; i++) begin
            f = 32'h3000 + 32'(i) * 32'h100;
            step(1, f, f + 32'hF, 1, f + 32'h80, f + 32'h8F, 0, '0, 0);
            idle_step();
        end

        step(1, 32'h2000, 32'h1FFF, 0, '0, '0, 0, '0, 0);
        idle_step();

        for (int i = 0; i <= int'(SIZE); i++) begin
            f = 32'h8000 + 32'(i) * 32'h10;
            step(1, f, f + 32'h7, 0, '0, '0, 0, '0, 0);
            idle_step();
        end
        clear_cycle();

        for (int i = 0; i < 12; i++)
            step(1, 32'h500 + 32'(i), 32'h600, 0, '0, '0, 1, 32'h550, 0);
        idle_step();

        n = 0;
        while (ph != P_CHK && n < 10) begin step(0, '0, '0, 0, '0, '0, 1, 32'h550, 0); n++; end
        if (ph != P_CHK) check_eq("chk_timeout", 1, 0);
        @(negedge clk_i);
        c_v = 0; rst_i = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clk_i);
        #1 check_reset_outputs();
        @(negedge clk_i) rst_i = 1'b0;
        idle_step(); idle_step();

        cr_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            f = 32'($urandom_range(0, 63)) * 32'h40;
            l = f + 32'($urandom_range(0, 100)) - 32'd8;
            if (cr_lvl && m_done) cr_lvl = 0;
            else if (!cr_lvl && $urandom_range(0, 39) == 0) cr_lvl = 1;
            step($urandom_range(0, 2) != 0, f, l,
                 $urandom_range(0, 2) != 0, f + 32'h20, l + 32'($urandom_range(0, 40)),
                 $urandom_range(0, 1) != 0, 32'($urandom_range(0, 4200)), cr_lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/range_buffer_ctrl.md
# range_buffer_ctrl

Sequencer and arbiter in front of the allocation range buffer (the SIZE-entry circular store of {first,last} address pairs with a combinational in-range lookup). It shares the buffer's single write port between two allocation requesters: A, the core commit path, and B, the CSR/debug path. It serialises address-check requests against those writes and drives the buffer's synchronous clear. It also tracks occupancy and overwrite of the oldest entry, so software can detect lost ranges.

## Interface
- SIZE, 32, entry count of the controlled buffer; power of two, ≥ 2.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- alloc_a_valid_i  in  1  requester A has a record.
- alloc_a_ready_o  out  1  requester A record accepted this cycle (valid & ready).
- alloc_a_first_i, alloc_a_last_i  in  32 each  requester A inclusive range.
- alloc_b_valid_i, alloc_b_ready_o, alloc_b_first_i, alloc_b_last_i  same roles for requester B.
- chk_valid_i  in  1  check request.
- chk_ready_o  out  1  check accepted.
- chk_addr_i  in  32  address to check.
- chk_valid_o  out  1  one-cycle result strobe.
- chk_hit_o  out  1  address lies in a stored range; valid only with chk_valid_o.
- clear_req_i  in  1  level request to flush the buffer; hold until clear_done_o.
- clear_done_o  out  1  one-cycle pulse after the flush.
- buf_en_write_o  out  1  buffer write strobe.
- buf_addr_first_o, buf_addr_last_o  out  32 each  buffer write data.
- buf_rst_us_o  out  1  buffer synchronous clear.
- buf_find_addr_o  out  32  buffer lookup address.
- buf_in_range_i  in  1  buffer lookup result (combinational in buffer).
- count_o  out  $clog2(SIZE)+1  valid entries, saturating at SIZE.
- wrapped_o  out  1  sticky: a write has overwritten a live entry.
- err_o  out  1  one-cycle pulse: malformed record dropped.

## Operation
- FSM states: IDLE, WRITE, CHECK, CLEAR. After reset the FSM is in IDLE.
- Handshakes are accepted only in IDLE. Ready outputs are combinational from state, the arbitration flags and the other ports' valids; they never depend on their own port's valid.
- IDLE priority is clear_req_i, then check, then alloc.
- Anti-starvation: if the previous IDLE decision served a check and any alloc valid is high, alloc beats check for this decision. The flag is named chk_last.
- Alloc arbitration is round-robin between A and B. The rr pointer toggles only on an accepted alloc. After reset, A has priority.
- Accepted alloc: capture first/last into registers and go to WRITE.
  - In WRITE, if first ≤ last (unsigned): buf_en_write_o=1 with the registered data; count_o increments unless already SIZE. If count_o==SIZE, set wrapped_o.
  - If first > last: no write, err_o=1 this cycle, count_o unchanged.
  - WRITE → IDLE.
- Accepted check: capture chk_addr_i and go to CHECK.
  - In CHECK, drive buf_find_addr_o with the registered address and register buf_in_range_i.
  - CHECK → IDLE, with chk_valid_o=1 and chk_hit_o set from that registered value during the following cycle.
- Clear: IDLE → CLEAR. In CLEAR, buf_rst_us_o=1 for exactly one cycle. Then count_o←0 and wrapped_o←0, clear_done_o=1 in the next cycle, and the FSM returns to IDLE.
- buf_find_addr_o holds its last value outside CHECK. buf_addr_*_o hold the registered data. Only the strobes qualify them.

## Timing
- Reset values: all outputs 0, count_o=0, wrapped_o=0. This also covers a reset asserted mid-operation: an in-flight write or check is dropped and no result strobe is produced.
- Alloc accepted at edge N: buf_en_write_o high in cycle N..N+1. The entry is visible to lookups from edge N+1. The next handshake can be accepted in cycle N+1..N+2.
- Check accepted at edge N: lookup in cycle N..N+1; chk_valid_o high in cycle N+1..N+2.
- Ordering: a check accepted after a write sees that write.
- Clear requested while the FSM is busy is honoured at the next IDLE. Valids presented during CLEAR are not accepted.
- Throughput: one operation per 2 cycles.

## Test plan
- Reset, then A sends {0x1000,0x10FF} while chk_valid_i is low. Required: alloc_a_ready_o=1 one cycle, then buf_en_write_o=1 with those values, count_o=1.
- After that write, check 0x10FF, then 0x1100. Required: results 2 cycles after each accept, chk_hit_o=1 then 0.
- A and B valid together for 4 records each. Required: grants alternate A,B,A,B…; B gets the first grant after A's.
- A sends {0x2000,0x1FFF}. Required: accepted, err_o pulse, no buf_en_write_o, count_o unchanged.
- SIZE+1 valid writes. Required: count_o saturates at SIZE, wrapped_o=1 from the SIZE+1st write. Then clear_req_i: one buf_rst_us_o pulse, clear_done_o next cycle, count_o=0, wrapped_o=0.
- Check and alloc continuously valid. Required: accepts alternate check/alloc. Also assert rst_i during a CHECK: no chk_valid_o, all outputs 0 immediately.
